// File: rtl/sync_dual_port_ram_pkg.sv
// Shared types and limits for the synchronous simple-dual-port RAM.
package sync_dual_port_ram_pkg;

   typedef enum logic {
      READ_FIRST  = 1'b0,
      WRITE_FIRST = 1'b1
   } collision_mode_e;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_e;

   localparam int unsigned MAX_RD_LATENCY = 4;

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-data delay line: STAGES register stages carrying data plus valid.
// Data only advances with its valid bit, so the output holds the last valid word.
module ram_rd_pipe #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned STAGES     = 0
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  valid_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  valid_o
);

   if (STAGES == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = clk_i ^ rst_ni;
      assign data_o  = data_i;
      assign valid_o = valid_i;
   end else begin : g_pipe
      logic [STAGES:1]       vld_pipe;
      logic [DATA_WIDTH-1:0] data_pipe [STAGES:1];

      always_ff @(posedge clk_i) begin
         if (!rst_ni) begin
            vld_pipe <= '0;
            for (int s = 1; s <= STAGES; s++) data_pipe[s] <= '0;
         end else begin
            vld_pipe[1] <= valid_i;
            if (valid_i) data_pipe[1] <= data_i;
            for (int s = 2; s <= STAGES; s++) begin
               vld_pipe[s] <= vld_pipe[s-1];
               if (vld_pipe[s-1]) data_pipe[s] <= data_pipe[s-1];
            end
         end
      end

      assign data_o  = data_pipe[STAGES];
      assign valid_o = vld_pipe[STAGES];
   end

endmodule

// File: rtl/sync_dual_port_ram.sv
// Single-clock simple-dual-port RAM with byte enables, pipelined registered read,
// selectable same-address collision behaviour and a post-reset clear sequencer.
module sync_dual_port_ram
   import sync_dual_port_ram_pkg::*;
#(
   parameter int unsigned     DATA_WIDTH     = 32,
   parameter int unsigned     ADDR_WIDTH     = 3,
   parameter int unsigned     BYTE_WIDTH     = 8,
   parameter int unsigned     RD_LATENCY     = 1,
   parameter collision_mode_e COLLISION_MODE = READ_FIRST,
   localparam int unsigned    NUM_BYTES      = DATA_WIDTH / BYTE_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  wr_en_i,
   input  logic [NUM_BYTES-1:0]  wr_be_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  rd_en_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  rd_valid_o,
   output logic                  init_done_o
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   if ((DATA_WIDTH % BYTE_WIDTH) != 0 || RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_param
      $error("sync_dual_port_ram: illegal DATA_WIDTH/BYTE_WIDTH/RD_LATENCY combination");
   end

   typedef logic [NUM_BYTES-1:0][BYTE_WIDTH-1:0] word_t;

   word_t                 mem [DEPTH];
   word_t                 wr_word, rd_word, rd_data_q;
   logic                  rd_vld_q;
   state_e                st_q, st_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  ready, wr_fire, rd_fire;

   assign ready   = (st_q == ST_READY);
   assign wr_fire = ready && wr_en_i;
   assign rd_fire = ready && rd_en_i;
   assign wr_word = wr_data_i;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         st_q  <= ST_INIT;
         cnt_q <= '0;
      end else begin
         st_q  <= st_d;
         cnt_q <= cnt_d;
      end
   end

   // Clear walks every address once, then the FSM parks in ST_READY until reset.
   always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      unique case (st_q)
         ST_INIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) st_d = ST_READY;
         end
         ST_READY: ;
         default: st_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         if (st_q == ST_INIT) begin
            mem[cnt_q] <= '0;
         end else if (wr_en_i) begin
            for (int b = 0; b < NUM_BYTES; b++)
               if (wr_be_i[b]) mem[wr_addr_i][b] <= wr_word[b];
         end
      end
   end

   // WRITE_FIRST forwards the enabled lanes of a same-address write into the read.
   always_comb begin
      rd_word = mem[rd_addr_i];
      if (COLLISION_MODE == WRITE_FIRST && wr_fire && wr_addr_i == rd_addr_i) begin
         for (int b = 0; b < NUM_BYTES; b++)
            if (wr_be_i[b]) rd_word[b] = wr_word[b];
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rd_vld_q  <= 1'b0;
         rd_data_q <= '0;
      end else begin
         rd_vld_q <= rd_fire;
         if (rd_fire) rd_data_q <= rd_word;
      end
   end

   ram_rd_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .STAGES     (RD_LATENCY - 1)
   ) u_rd_pipe (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .data_i  (rd_data_q),
      .valid_i (rd_vld_q),
      .data_o  (rd_data_o),
      .valid_o (rd_valid_o)
   );

   assign init_done_o = ready;

endmodule

// File: tb/tb_sync_dual_port_ram.sv
// Directed bench: a READ_FIRST/latency-3 RAM and a WRITE_FIRST/latency-1 RAM share stimulus.
module tb_sync_dual_port_ram;
   import sync_dual_port_ram_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, wr_en, rd_en;
   logic [3:0]  wr_be;
   logic [2:0]  wr_addr, rd_addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data_rf, rd_data_wf;
   logic        rd_valid_rf, rd_valid_wf, done_rf, done_wf;
   int          n_chk = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   sync_dual_port_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .BYTE_WIDTH(8), .RD_LATENCY(3),
                        .COLLISION_MODE(READ_FIRST)) dut (
      .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_be_i(wr_be), .wr_addr_i(wr_addr),
      .wr_data_i(wr_data), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data_rf),
      .rd_valid_o(rd_valid_rf), .init_done_o(done_rf));

   sync_dual_port_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .BYTE_WIDTH(8), .RD_LATENCY(1),
                        .COLLISION_MODE(WRITE_FIRST)) dut_wf (
      .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_be_i(wr_be), .wr_addr_i(wr_addr),
      .wr_data_i(wr_data), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data_wf),
      .rd_valid_o(rd_valid_wf), .init_done_o(done_wf));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
      tick();
      wr_en = 1'b0; wr_be = '0;
   endtask

   // Issues one read and checks data and latency on both instances within a bounded window.
   task automatic check_read(input string tag, input logic [2:0] a,
                             input logic [31:0] exp_rf, input logic [31:0] exp_wf);
      logic [31:0] d_rf, d_wf;
      int          l_rf, l_wf;
      rd_en = 1'b1; rd_addr = a;
      l_rf = -1; l_wf = -1; d_rf = '0; d_wf = '0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         rd_en = 1'b0;
         if (rd_valid_rf && l_rf < 0) begin l_rf = k; d_rf = rd_data_rf; end
         if (rd_valid_wf && l_wf < 0) begin l_wf = k; d_wf = rd_data_wf; end
      end
      chk({tag, "_rf_data"}, d_rf, exp_rf);
      chk({tag, "_rf_lat"}, 32'(l_rf), 32'd3);
      chk({tag, "_wf_data"}, d_wf, exp_wf);
      chk({tag, "_wf_lat"}, 32'(l_wf), 32'd1);
   endtask

   initial begin
      logic seen_vld;
      rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_be = '0;
      wr_addr = '0; rd_addr = '0; wr_data = '0;
      tick(); tick(); tick();
      chk("rst_done", 32'(done_rf), 32'd0);
      chk("rst_valid", 32'(rd_valid_rf), 32'd0);
      chk("rst_data", rd_data_rf, 32'd0);

      // Init clear, with a stray write/read at init cycle 3.
      rst_n = 1'b1;
      seen_vld = 1'b0;
      for (int c = 0; c < 8; c++) begin
         wr_en = (c == 3); rd_en = (c == 3); wr_be = 4'hF;
         wr_addr = 3'd2; rd_addr = 3'd2; wr_data = 32'hDEADBEEF;
         tick();
         seen_vld |= rd_valid_rf | rd_valid_wf;
         chk($sformatf("init_done_c%0d", c), 32'(done_rf), (c == 7) ? 32'd1 : 32'd0);
      end
      wr_en = 1'b0; rd_en = 1'b0; wr_be = '0;
      chk("init_wf_done", 32'(done_wf), 32'd1);
      tick(); tick(); tick();
      seen_vld |= rd_valid_rf | rd_valid_wf;
      chk("init_read_ignored", 32'(seen_vld), 32'd0);
      for (int a = 0; a < 8; a++) check_read($sformatf("clr%0d", a), 3'(a), 32'd0, 32'd0);

      // Byte enables and no-op enable mask.
      wr(3'd5, 32'h11223344, 4'hF);
      wr(3'd5, 32'hAABBCCDD, 4'b0101);
      check_read("be_merge", 3'd5, 32'h11BB33DD, 32'h11BB33DD);
      wr(3'd5, 32'hFFFFFFFF, 4'b0000);
      check_read("be_none", 3'd5, 32'h11BB33DD, 32'h11BB33DD);

      // Throughput: four back-to-back reads.
      for (int i = 0; i < 4; i++) wr(3'(i), 32'h1000_0000 + i, 4'hF);
      for (int k = 1; k <= 9; k++) begin
         rd_en = (k <= 4); rd_addr = 3'(k - 1);
         tick();
         chk($sformatf("tp_rf_vld%0d", k), 32'(rd_valid_rf), (k >= 3 && k <= 6) ? 32'd1 : 32'd0);
         if (k >= 3 && k <= 6) chk($sformatf("tp_rf_dat%0d", k), rd_data_rf, 32'h1000_0000 + 32'(k - 3));
         if (k > 6) chk($sformatf("tp_rf_hold%0d", k), rd_data_rf, 32'h1000_0003);
         chk($sformatf("tp_wf_vld%0d", k), 32'(rd_valid_wf), (k <= 4) ? 32'd1 : 32'd0);
         if (k <= 4) chk($sformatf("tp_wf_dat%0d", k), rd_data_wf, 32'h1000_0000 + 32'(k - 1));
      end
      rd_en = 1'b0;

      // Same-address collision.
      wr(3'd1, 32'h0000AAAA, 4'hF);
      wr_en = 1'b1; wr_addr = 3'd1; wr_data = 32'h12345678; wr_be = 4'b0011;
      check_read("coll", 3'd1, 32'h0000AAAA, 32'h00005678);
      check_read("coll_after", 3'd1, 32'h00005678, 32'h00005678);

      // Different-address simultaneous read/write.
      wr_en = 1'b1; wr_addr = 3'd6; wr_data = 32'h600DF00D; wr_be = 4'hF;
      check_read("indep_rd", 3'd5, 32'h11BB33DD, 32'h11BB33DD);
      check_read("indep_wr", 3'd6, 32'h600DF00D, 32'h600DF00D);

      // A write after the sampling edge must not reach data already in the pipe.
      for (int k = 1; k <= 4; k++) begin
         rd_en = (k == 1); rd_addr = 3'd7;
         wr_en = (k == 2); wr_addr = 3'd7; wr_data = 32'hCAFEF00D; wr_be = 4'hF;
         tick();
         if (k == 3) begin
            chk("pipe_frozen_vld", 32'(rd_valid_rf), 32'd1);
            chk("pipe_frozen_dat", rd_data_rf, 32'd0);
         end
      end
      rd_en = 1'b0; wr_en = 1'b0; wr_be = '0;

      // Reset with two reads in flight.
      seen_vld = 1'b0;
      for (int k = 1; k <= 11; k++) begin
         rd_en = (k <= 2); rd_addr = (k == 1) ? 3'd3 : 3'd0;
         rst_n = (k != 3);
         tick();
         if (k >= 3) seen_vld |= rd_valid_rf;
         if (k == 3) chk("mid_rst_data", rd_data_rf, 32'd0);
         if (k >= 3) chk($sformatf("mid_rst_done%0d", k), 32'(done_rf), (k == 11) ? 32'd1 : 32'd0);
      end
      rd_en = 1'b0; rst_n = 1'b1;
      chk("mid_rst_no_vld", 32'(seen_vld), 32'd0);
      for (int a = 0; a < 8; a++) check_read($sformatf("reclr%0d", a), 3'(a), 32'd0, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sync_dual_port_ram.md
Name: sync_dual_port_ram

Overview:
Single-clock simple-dual-port RAM: one write port and one read port. It succeeds the asynchronous-read dual-port RAM used across rtl_lib and adds the following:
- registered, pipelined read with a valid strobe
- per-byte write enables
- selectable same-address collision mode
- a self-clearing init sequencer that zeroes the array after reset
Intended for FIFOs, scoreboards and buffers that need deterministic post-reset contents and a timing-friendly read path.

Parameters:
DATA_WIDTH, 32, data word width; must be a multiple of BYTE_WIDTH
ADDR_WIDTH, 3, address width; DEPTH = 1 << ADDR_WIDTH
BYTE_WIDTH, 8, bits per write-enable lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH
RD_LATENCY, 1, cycles from rd_en_i sample to rd_valid_o; legal 1..4
COLLISION_MODE, READ_FIRST, same-address read/write behaviour: READ_FIRST or WRITE_FIRST

Ports:
clk_i  input  1  single clock; all logic on its rising edge
rst_ni  input  1  synchronous, active-low reset
wr_en_i  input  1  write request
wr_be_i  input  NUM_BYTES  byte-lane write enables
wr_addr_i  input  ADDR_WIDTH  write address
wr_data_i  input  DATA_WIDTH  write data
rd_en_i  input  1  read request
rd_addr_i  input  ADDR_WIDTH  read address
rd_data_o  output  DATA_WIDTH  read data; qualified by rd_valid_o
rd_valid_o  output  1  one-cycle pulse per accepted read
init_done_o  output  1  high once the array clear completes

Behaviour:
- Clocking and reset: one clock, clk_i. Reset rst_ni is synchronous and active-low.
- Values while rst_ni=0 (sampled at an edge):
  - FSM goes to ST_INIT and the clear counter goes to 0.
  - init_done_o=0, rd_valid_o=0, rd_data_o=0.
  - All read-pipeline valid bits are cleared.
  - The array itself is not reset directly.
- ST_INIT:
  - Each cycle, writes 0 to mem[cnt] and increments cnt.
  - Cycle 0 is the first edge with rst_ni=1. Addresses 0..DEPTH-1 are written in cycles 0..DEPTH-1.
  - After the write of DEPTH-1 the FSM moves to ST_READY, so init_done_o=1 from cycle DEPTH onward.
  - User writes are dropped and user reads are ignored: no rd_valid_o is generated for them.
- ST_READY:
  - Stays in this state until reset.
  - init_done_o stays at 1.
- Reset asserted mid-init or mid-read: the FSM returns to ST_INIT and the clear restarts at address 0. In-flight reads are discarded and their rd_valid_o never fires.
- Write (ST_READY, wr_en_i=1): for each lane b with wr_be_i[b]=1, set mem[wr_addr_i][b] <= wr_data_i[b]. Other lanes are unchanged. wr_be_i=0 is a legal no-op.
- Read (ST_READY, rd_en_i=1):
  - The array is read at the sampling edge (stage 1).
  - Data and valid then shift through RD_LATENCY-1 further register stages.
  - rd_valid_o pulses exactly RD_LATENCY cycles after the rd_en_i edge.
  - Back-to-back reads give full throughput: one result per cycle, in order.
- rd_data_o holds its last valid value while rd_valid_o=0.
- Collision (read and write in the same cycle, same address, ST_READY):
  - READ_FIRST: returns the pre-write word.
  - WRITE_FIRST: returns the merged word (enabled lanes from wr_data_i, the rest old).
  - Writes after the sampling edge never alter data already in the pipeline.
- Simultaneous read/write to different addresses: fully independent.
- Address wrap: addresses are modulo DEPTH by width; there is no out-of-range case.
- Elaboration-time checks: illegal parameters (DATA_WIDTH % BYTE_WIDTH != 0, or RD_LATENCY outside 1..4) raise an elaboration error.

Decomposition:
- Package sync_dual_port_ram_pkg:
  - collision_mode_e {READ_FIRST, WRITE_FIRST}
  - state_e {ST_INIT, ST_READY}
  - MAX_RD_LATENCY = 4
- Sub-module ram_rd_pipe: a parametrised DATA_WIDTH+1-bit shift register of depth RD_LATENCY-1 carrying data and valid. It has a synchronous active-low valid flush and is instantiated once; depth 0 is a pass-through.

Test Plan:
All scenarios use DATA_WIDTH=32, ADDR_WIDTH=3.
1. Init clear: release reset, read every address 0..7.
   -> init_done_o rises at cycle 8; every read returns 0x00000000.
2. Init is ignored: issue wr_en_i (addr 2, 0xDEADBEEF) and rd_en_i at cycle 3 of init.
   -> No rd_valid_o; a later read of addr 2 returns 0.
3. Byte enables: write 0x11223344 with be=4'hF to addr 5, then 0xAABBCCDD with be=4'b0101.
   -> Read of addr 5 returns 0x11BB33DD.
4. Latency and throughput: with RD_LATENCY=3, issue reads on 4 consecutive cycles.
   -> rd_valid_o high for 4 consecutive cycles starting 3 cycles after the first request, data in order.
5. Collision: addr 1 holds 0x0000AAAA; in one cycle write 0x12345678 with be=4'b0011 and read addr 1.
   -> READ_FIRST returns 0x0000AAAA; WRITE_FIRST returns 0x00005678.
6. Reset mid-operation: pulse rst_ni low for 1 cycle with 2 reads in flight and memory written.
   -> No rd_valid_o for those reads; init_done_o=0 for 8 cycles; all addresses then read 0.
